// File: rtl/result_collector.sv
// Result collector: round-robin gathers finished pixels from the worker
// array and writes each one into the frame buffer.
//
// Ports:
//   clk, rst       system clock; synchronous active-high reset
//   clear          start a new frame (abort, zero counters, back to SCAN)
//   jw_rc_valid    per-worker "pixel ready" flags
//   jw_x/jw_y      per-worker pixel coordinates, stable while valid
//   jw_iter        per-worker iteration count (pixel data)
//   rc_jw_ack      one-hot, one-cycle pulse: that worker's pixel was taken
//   mem_wr_en      frame-buffer write request, held until mem_ready
//   mem_addr       y*(X_MAX+1)+x
//   mem_wdata      iteration count
//   mem_ready      frame buffer accepts the write this cycle
//   pix_count      pixels written in this frame
//   frame_done     high from the last write until clear/rst
//   coord_err      sticky: an out-of-range pixel was dropped
module result_collector #(
    parameter int NUM_WORKERS = 16,
    parameter int COORD_W     = 10,
    parameter int ITER_W      = 8,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int ADDR_W      = 19
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [NUM_WORKERS-1:0]               jw_rc_valid,
    input  logic [NUM_WORKERS-1:0][COORD_W-1:0]  jw_x,
    input  logic [NUM_WORKERS-1:0][COORD_W-1:0]  jw_y,
    input  logic [NUM_WORKERS-1:0][ITER_W-1:0]   jw_iter,
    output logic [NUM_WORKERS-1:0]               rc_jw_ack,
    output logic                                 mem_wr_en,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [ITER_W-1:0]                    mem_wdata,
    input  logic                                 mem_ready,
    output logic [ADDR_W-1:0]                    pix_count,
    output logic                                 frame_done,
    output logic                                 coord_err
);

    localparam int PTR_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

    localparam logic [COORD_W-1:0] XM     = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YM     = COORD_W'(Y_MAX);
    localparam logic [ADDR_W-1:0]  STRIDE = ADDR_W'(X_MAX + 1);
    localparam logic [ADDR_W-1:0]  TOTAL  = ADDR_W'((X_MAX + 1) * (Y_MAX + 1));

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state, state_n;
    logic [PTR_W-1:0]         rr_ptr, rr_n;
    logic [NUM_WORKERS-1:0]   ack_n;
    logic                     wr_n;
    logic [ADDR_W-1:0]        addr_n;
    logic [ITER_W-1:0]        data_n;
    logic [ADDR_W-1:0]        pix_n;
    logic                     fd_n;
    logic                     ce_n;

    logic [NUM_WORKERS-1:0]   cand;
    logic                     found;
    logic [PTR_W-1:0]         sel;
    logic [PTR_W-1:0]         idx;
    logic [COORD_W-1:0]       sx, sy;
    logic                     in_range;
    logic [ADDR_W-1:0]        pix_inc;

    // The worker acked this cycle may still show valid for one cycle;
    // mask it so a lone worker cannot be captured twice.
    assign cand = jw_rc_valid & ~rc_jw_ack;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            idx = rr_ptr + PTR_W'(i);
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign sx       = jw_x[sel];
    assign sy       = jw_y[sel];
    assign in_range = (sx <= XM) && (sy <= YM);
    assign pix_inc  = pix_count + ADDR_W'(1);

    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        ack_n   = '0;
        wr_n    = mem_wr_en;
        addr_n  = mem_addr;
        data_n  = mem_wdata;
        pix_n   = pix_count;
        fd_n    = frame_done;
        ce_n    = coord_err;
        if (clear) begin
            state_n = SCAN;
            rr_n    = '0;
            wr_n    = 1'b0;
            pix_n   = '0;
            fd_n    = 1'b0;
            ce_n    = 1'b0;
        end else begin
            unique case (state)
                SCAN: begin
                    if (found) begin
                        ack_n[sel] = 1'b1;
                        rr_n       = sel + PTR_W'(1);
                        if (in_range) begin
                            state_n = WRITE;
                            wr_n    = 1'b1;
                            addr_n  = ADDR_W'(sy) * STRIDE + ADDR_W'(sx);
                            data_n  = jw_iter[sel];
                        end else begin
                            ce_n = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        wr_n  = 1'b0;
                        pix_n = pix_inc;
                        if (pix_inc == TOTAL) begin
                            state_n = DONE;
                            fd_n    = 1'b1;
                        end else begin
                            state_n = SCAN;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_n = SCAN;
                    wr_n    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SCAN;
            rr_ptr     <= '0;
            rc_jw_ack  <= '0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pix_count  <= '0;
            frame_done <= 1'b0;
            coord_err  <= 1'b0;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_n;
            rc_jw_ack  <= ack_n;
            mem_wr_en  <= wr_n;
            mem_addr   <= addr_n;
            mem_wdata  <= data_n;
            pix_count  <= pix_n;
            frame_done <= fd_n;
            coord_err  <= ce_n;
        end
    end

endmodule
